// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter for four requesters sharing a 4:1 mux.
// It issues a registered one-hot grant and the matching select lines, and caps each grant's length.
module mux_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 15,
  parameter int unsigned HOLD_W   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic       S1,
  output logic       S0,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e            state_q, state_d;
  logic [3:0]        gnt_q, gnt_d;
  logic [1:0]        sel_q, sel_d;
  logic [1:0]        last_q, last_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic              timeout_q, timeout_d;

  logic       at_limit, forced_rel, release_c;
  logic [3:0] cand;
  logic [2:0] win;

  // Returns {found, index} of the first set bit at or after last+1, wrapping around.
  function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] last);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!res[2] && r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    at_limit   = (cnt_q == HOLD_W'(MAX_HOLD - 1));
    forced_rel = at_limit && !done && req[last_q];
    release_c  = done || !req[last_q] || at_limit;
    // A forced release must actually give the mux up, so the timed-out owner sits out one round.
    cand       = req;
    if (state_q == StGrant && forced_rel) cand = req & ~(4'b0001 << last_q);
    win        = pick(cand, last_q);
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (win[2]) begin
          state_d = StGrant;
          gnt_d   = 4'b0001 << win[1:0];
          sel_d   = win[1:0];
          last_d  = win[1:0];
          cnt_d   = '0;
        end
      end
      StGrant: begin
        cnt_d = cnt_q + 1'b1;
        if (release_c) begin
          timeout_d = forced_rel;
          if (win[2]) begin
            gnt_d  = 4'b0001 << win[1:0];
            sel_d  = win[1:0];
            last_d = win[1:0];
            cnt_d  = '0;
          end else begin
            state_d = StIdle;
            gnt_d   = 4'b0000;
            cnt_d   = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      gnt_q     <= 4'b0000;
      sel_q     <= 2'b00;
      last_q    <= 2'd3;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt     = gnt_q;
  assign S1      = sel_q[1];
  assign S0      = sel_q[0];
  assign busy    = (state_q == StGrant);
  assign timeout = timeout_q;

endmodule
